alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer_if.sv | 23 ++
 rtl/alu_cmd_sequencer.sv | 116 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// Command/response handshake bundle between an upstream requester and alu_cmd_sequencer.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_result;
    logic       rsp_zero;
    logic [2:0] rsp_op;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_op
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_op
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a 4-deep FIFO and sequences them one at a time through a
// registered downstream alu_4bit, returning each result over a valid/ready response.
module alu_cmd_sequencer (
    input  logic                      clk,
    input  logic                      rst_n,
    alu_cmd_sequencer_if.slave        bus,
    output logic [3:0]                alu_a,
    output logic [3:0]                alu_b,
    output logic [2:0]                alu_op_code,
    input  logic [4:0]                alu_result,
    input  logic                      alu_zero_flag,
    output logic                      err_illegal,
    output logic                      busy
);
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, RESP} state_t;

    state_t     state;
    cmd_t       fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    cmd_t       head;
    logic       push;
    logic       pop;

    logic       rsp_valid_q;
    logic [4:0] rsp_result_q;
    logic       rsp_zero_q;
    logic [2:0] rsp_op_q;

    // Ready depends only on the registered count, so a full FIFO never writes through on a pop.
    assign bus.cmd_ready = (count != 3'd4);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && (count != 3'd0);
    assign head          = fifo_mem[rd_ptr];

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_op     = rsp_op_q;
    assign busy           = (state != IDLE) || (count != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op_code  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_op_q     <= '0;
            err_illegal  <= 1'b0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        // Illegal opcodes are dropped without touching the ALU operands.
                        if (head.op == OP_ILLEGAL) begin
                            err_illegal <= 1'b1;
                        end else begin
                            alu_a       <= head.a;
                            alu_b       <= head.b;
                            alu_op_code <= head.op;
                            state       <= EXEC;
                        end
                    end
                end
                EXEC: state <= CAPTURE;
                CAPTURE: begin
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= alu_zero_flag;
                    rsp_op_q     <= alu_op_code;
                    rsp_valid_q  <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed bench for alu_cmd_sequencer with a transaction-level reference model.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus();

    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op_code;
    logic [4:0] alu_result = '0;
    logic       alu_zero_flag = 1'b0;
    logic       err_illegal, busy;

    logic       cv = 1'b0;
    logic [3:0] ca = '0, cb = '0;
    logic [2:0] co = '0;
    logic       rr = 1'b1;
    assign bus.cmd_valid = cv;
    assign bus.cmd_a     = ca;
    assign bus.cmd_b     = cb;
    assign bus.cmd_op    = co;
    assign bus.rsp_ready = rr;

    alu_cmd_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op_code  (alu_op_code),
        .alu_result   (alu_result),
        .alu_zero_flag(alu_zero_flag),
        .err_illegal  (err_illegal),
        .busy         (busy)
    );

    function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int ia, ib, r;
        ia = a;
        ib = b;
        case (op)
            3'd0:    r = ia + ib;
            3'd1:    r = ia - ib;
            3'd2:    r = ia & ib;
            3'd3:    r = ia | ib;
            3'd4:    r = ia ^ ib;
            3'd5:    r = ia * 2;
            3'd6:    r = ia / 2;
            default: r = 0;
        endcase
        return r[4:0];
    endfunction

    // Downstream alu_4bit stand-in: result registered one clock after its inputs.
    always @(posedge clk) begin
        alu_result    <= alu_fn(alu_a, alu_b, alu_op_code);
        alu_zero_flag <= (alu_fn(alu_a, alu_b, alu_op_code) == 5'd0);
    end

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } cmd_t;

    cmd_t       mq[$];
    bit         m_busy, m_rvld, m_err, m_push;
    int         m_age, m_hs;
    logic [3:0] m_a, m_b;
    logic [2:0] m_op, m_rop;
    logic [4:0] m_res;
    logic       m_zero;

    int checks = 0, errors = 0;
    int err_seen = 0, rsp_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_rvld = 0; m_err = 0; m_push = 0; m_age = 0;
        m_a = '0; m_b = '0; m_op = '0; m_rop = '0; m_res = '0; m_zero = 1'b0;
    endtask

    // One clock edge of the transaction model, using the pre-edge stimulus.
    task automatic model_edge();
        bit   ready;
        cmd_t c;
        m_err  = 0;
        m_push = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ready = (mq.size() != 4);
        if (m_busy) begin
            if (m_rvld) begin
                if (rr) begin m_rvld = 0; m_busy = 0; m_hs++; end
            end else begin
                m_age++;
                if (m_age == 2) begin
                    m_rvld = 1;
                    m_res  = alu_fn(m_a, m_b, m_op);
                    m_zero = (m_res == 5'd0);
                    m_rop  = m_op;
                end
            end
        end else if (mq.size() > 0) begin
            c = mq.pop_front();
            if (c.op == 3'b111) m_err = 1;
            else begin
                m_busy = 1; m_age = 0;
                m_a = c.a; m_b = c.b; m_op = c.op;
            end
        end
        if (cv && ready) begin
            mq.push_back('{a: ca, b: cb, op: co});
            m_push = 1;
        end
    endtask

    task automatic check_all();
        chk("cmd_ready", bus.cmd_ready, mq.size() != 4);
        chk("busy", busy, m_busy || (mq.size() != 0));
        chk("err_illegal", err_illegal, m_err);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_op_code", alu_op_code, m_op);
        chk("rsp_valid", bus.rsp_valid, m_rvld);
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_zero", bus.rsp_zero, m_zero);
        chk("rsp_op", bus.rsp_op, m_rop);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        if (err_illegal === 1'b1) err_seen++;
        if (bus.rsp_valid === 1'b1) rsp_seen++;
    endtask

    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, output int n);
        n = 0;
        cv = 1'b1; ca = a; cb = b; co = op;
        do begin step(); n++; end while (!m_push && n < 50);
        if (!m_push) chk("push_timeout", 32'd0, 32'd1);
        cv = 1'b0;
    endtask

    task automatic wait_rsp(input logic [4:0] er, input logic ez, input logic [2:0] eo, output int n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin step(); n++; end
        if (bus.rsp_valid !== 1'b1) chk("rsp_timeout", 32'd0, 32'd1);
        else begin
            chk("lit_rsp_result", bus.rsp_result, er);
            chk("lit_rsp_zero", bus.rsp_zero, ez);
            chk("lit_rsp_op", bus.rsp_op, eo);
        end
    endtask

    task automatic drain();
        int n = 0;
        rr = 1'b1;
        while ((busy === 1'b1 || bus.rsp_valid === 1'b1) && n < 100) begin step(); n++; end
        if (busy !== 1'b0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int n, hs0;
        model_reset();
        m_hs = 0;
        // Write attempt while held in reset must be ignored.
        cv = 1'b1; ca = 4'd9; cb = 4'd1; co = 3'd0;
        repeat (3) step();
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        cv = 1'b0;
        rst_n = 1'b1;
        step();

        // ADD with latency
        push_cmd(4'd3, 4'd2, 3'd0, n);
        wait_rsp(5'd5, 1'b0, 3'd0, n);
        chk("add_latency", n, 3);
        step();

        // SUB to zero and with borrow
        push_cmd(4'd2, 4'd2, 3'd1, n);
        wait_rsp(5'd0, 1'b1, 3'd1, n);
        step();
        push_cmd(4'd2, 4'd7, 3'd1, n);
        wait_rsp(5'b11011, 1'b0, 3'd1, n);
        step();

        // Full FIFO: six back-to-back commands
        hs0 = m_hs;
        for (int i = 0; i < 6; i++) begin
            push_cmd(4'(i + 1), 4'(i + 3), 3'(i % 7), n);
            if (i < 5) chk("full_push_edge", n, 1);
            else chk("cmd6_wait", n, 2);
            if (i == 4) chk("full_ready_low", bus.cmd_ready, 1'b0);
        end
        drain();
        chk("full_rsp_count", m_hs - hs0, 6);

        // Backpressure for 10 cycles in RESP
        rr = 1'b0;
        push_cmd(4'd1, 4'd2, 3'd0, n);
        push_cmd(4'd4, 4'd4, 3'd4, n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin step(); n++; end
        repeat (10) step();
        chk("bp_hold_result", bus.rsp_result, 5'd3);
        chk("bp_no_pop", alu_a, 4'd1);
        rr = 1'b1;
        step();
        chk("bp_handshake", bus.rsp_valid, 1'b0);
        step();
        chk("bp_next_pop", alu_a, 4'd4);
        drain();

        // Illegal opcode dropped, following command still served
        err_seen = 0;
        push_cmd(4'd5, 4'd5, 3'd7, n);
        push_cmd(4'd12, 4'd10, 3'd2, n);
        wait_rsp(5'd8, 1'b0, 3'd2, n);
        drain();
        chk("illegal_pulses", err_seen, 1);

        // Reset while in EXEC with two commands queued
        rr = 1'b0;
        push_cmd(4'd1, 4'd1, 3'd0, n);
        push_cmd(4'd2, 4'd2, 3'd0, n);
        push_cmd(4'd3, 4'd3, 3'd3, n);
        push_cmd(4'd4, 4'd1, 3'd1, n);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin step(); n++; end
        rr = 1'b1;
        step();
        step();
        chk("pre_rst_queued", mq.size(), 2);
        chk("pre_rst_alu_a", alu_a, 4'd2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_alu_a", alu_a, 4'd0);
        chk("async_rst_rsp_valid", bus.rsp_valid, 1'b0);
        step();
        rst_n = 1'b1;
        rsp_seen = 0;
        repeat (10) step();
        chk("post_rst_no_rsp", rsp_seen, 0);
        chk("post_rst_busy", busy, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cv = ($urandom_range(0, 1) == 1);
            ca = 4'($urandom_range(0, 15));
            cb = 4'($urandom_range(0, 15));
            co = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            rr = ($urandom_range(0, 3) != 0);
            step();
        end
        cv = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
